// File: rtl/dmem_io_arbiter.sv
// Arbitrates the shared synchronous-read data RAM and MMIO bus between the MEM stage and a
// debug read port; decodes RAM/MMIO space, sequences read latency, and ages waiting debug reads.
//
//   state  | meaning
//   IDLE   | accepting commands; CPU writes complete here in one cycle
//   CPU_RD | RAM read issued for the CPU; mem_rdata returns this cycle
//   IO_RD  | MMIO read strobed for the CPU; io_din returns this cycle
//   DBG_RD | RAM read issued for debug; mem_rdata returns this cycle
module dmem_io_arbiter #(
  parameter int          AW           = 8,
  parameter logic [31:0] IO_BASE      = 32'h0000_FF00,
  parameter int          DBG_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [7:0]    io_addr,
  output logic [31:0]   io_dout,
  output logic          io_we,
  output logic          io_rd,
  input  logic [31:0]   io_din
);

  localparam int AGE_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    IO_RD  = 2'd2,
    DBG_RD = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      dbg_rdata_q, dbg_rdata_d;
  logic             cpu_is_io;
  logic             dbg_grant;
  logic             cpu_grant;

  assign cpu_is_io = (cpu_addr[31:8] == IO_BASE[31:8]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      age_q       <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Outputs are combinational from state and inputs; gating on rst_n keeps every
  // strobe and address at zero while reset is asserted, even with requests held.
  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_grant   = 1'b0;
    cpu_grant   = 1'b0;
    cpu_rdata   = cpu_rdata_q;
    cpu_done    = 1'b0;
    dbg_rdata   = dbg_rdata_q;
    dbg_valid   = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    io_addr     = '0;
    io_dout     = '0;
    io_we       = 1'b0;
    io_rd       = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (dbg_req && ((age_q == AGE_MAX) || !cpu_req)) begin
            dbg_grant = 1'b1;
          end else if (cpu_req) begin
            cpu_grant = 1'b1;
          end
          if (dbg_grant) begin
            mem_addr = dbg_addr;
            state_d  = DBG_RD;
          end else if (cpu_grant) begin
            if (cpu_is_io) begin
              io_addr = cpu_addr[7:0];
              if (cpu_we) begin
                io_we   = 1'b1;
                io_dout = cpu_wdata;
              end else begin
                io_rd   = 1'b1;
                state_d = IO_RD;
              end
            end else begin
              mem_addr = cpu_addr[AW+1:2];
              if (cpu_we) begin
                mem_we    = 1'b1;
                mem_wdata = cpu_wdata;
              end else begin
                state_d = CPU_RD;
              end
            end
          end
        end
        CPU_RD: begin
          cpu_done    = 1'b1;
          cpu_rdata   = mem_rdata;
          cpu_rdata_d = mem_rdata;
          state_d     = IDLE;
        end
        IO_RD: begin
          cpu_done    = 1'b1;
          cpu_rdata   = io_din;
          cpu_rdata_d = io_din;
          state_d     = IDLE;
        end
        DBG_RD: begin
          dbg_valid   = 1'b1;
          dbg_rdata   = mem_rdata;
          dbg_rdata_d = mem_rdata;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Age counts CPU wins over a pending debug request; saturates so the forced grant sticks.
  always_comb begin
    age_d = age_q;
    if (!dbg_req || dbg_grant) begin
      age_d = '0;
    end else if (cpu_grant && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  assign cpu_stall = rst_n && cpu_req &&
                     ((!cpu_we && !cpu_done) || (state_q == DBG_RD) || dbg_grant);

endmodule
